// File: rtl/task_10_seq.sv
// rtl/task_10_seq.sv - packet sequencer for the task_10 dot-product pipeline
// Counts bytes, words and results per packet and gates the answer drain.
module task_10_seq #(
    parameter int NUM_BYTES_IN   = 320,
    parameter int WORDS_PER_VEC  = 8,
    parameter int NUM_RESULTS    = 20,
    parameter int RESULT_BYTES   = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tdata_valid,
    input  logic        i_tdata_last,
    output logic        o_tready,
    input  logic        i_word_valid,
    input  logic        i_result_valid,
    input  logic        i_tmanager_ready,
    input  logic        i_out_last,
    output logic        o_out_start,
    output logic        o_des_clear,
    output logic [11:0] o_packet_size_in_bytes,
    output logic        o_busy,
    output logic [2:0]  o_state,
    output logic        o_err
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RECV     = 3'd1,
        FLUSH    = 3'd2,
        WAIT_MGR = 3'd3,
        SEND     = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [11:0] byte_cnt, byte_cnt_n, byte_inc;
    logic [9:0]  word_cnt, word_cnt_n, exp_res;
    logic [7:0]  res_cnt, res_cnt_n;
    logic [15:0] to_cnt, to_cnt_n;
    logic [11:0] pkt_size_n;
    logic        tready_n, out_start_n, des_clear_n, err_n;
    logic        res_err, done, timeout;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state                  <= IDLE;
            byte_cnt               <= '0;
            word_cnt               <= '0;
            res_cnt                <= '0;
            to_cnt                 <= '0;
            o_tready               <= 1'b0;
            o_out_start            <= 1'b0;
            o_des_clear            <= 1'b0;
            o_packet_size_in_bytes <= '0;
            o_err                  <= 1'b0;
        end else begin
            state                  <= state_n;
            byte_cnt               <= byte_cnt_n;
            word_cnt               <= word_cnt_n;
            res_cnt                <= res_cnt_n;
            to_cnt                 <= to_cnt_n;
            o_tready               <= tready_n;
            o_out_start            <= out_start_n;
            o_des_clear            <= des_clear_n;
            o_packet_size_in_bytes <= pkt_size_n;
            o_err                  <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        byte_cnt_n  = byte_cnt;
        word_cnt_n  = word_cnt;
        res_cnt_n   = res_cnt;
        to_cnt_n    = to_cnt;
        pkt_size_n  = o_packet_size_in_bytes;
        err_n       = o_err;
        out_start_n = 1'b0;
        des_clear_n = 1'b0;
        res_err     = 1'b0;
        byte_inc    = byte_cnt + 12'd1;
        exp_res     = word_cnt / 10'(WORDS_PER_VEC);
        done        = {2'b00, res_cnt} >= exp_res;
        timeout     = (to_cnt + 16'd1) == 16'(TIMEOUT_CYCLES);

        // Results only belong to a packet while it is receiving or flushing.
        if (i_result_valid) begin
            if ((state == RECV) || (state == FLUSH)) begin
                if (res_cnt == 8'(NUM_RESULTS))
                    res_err = 1'b1;
                else
                    res_cnt_n = res_cnt + 8'd1;
            end else begin
                res_err = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (i_tdata_valid) begin
                    byte_cnt_n = 12'd1;
                    err_n      = 1'b0;
                    if (i_tdata_last) begin
                        err_n   = 1'b1;
                        state_n = FLUSH;
                    end else begin
                        state_n = RECV;
                    end
                end
            end
            RECV: begin
                if (i_word_valid)
                    word_cnt_n = word_cnt + 10'd1;
                if (i_tdata_valid) begin
                    byte_cnt_n = byte_inc;
                    if (i_tdata_last) begin
                        state_n = FLUSH;
                        if (byte_inc != 12'(NUM_BYTES_IN))
                            err_n = 1'b1;
                    end else if (byte_inc == 12'(NUM_BYTES_IN)) begin
                        state_n = FLUSH;
                        err_n   = 1'b1;
                    end
                end
            end
            FLUSH: begin
                to_cnt_n = to_cnt + 16'd1;
                if ((word_cnt % 10'(WORDS_PER_VEC)) != 10'd0)
                    err_n = 1'b1;
                if (done || timeout) begin
                    state_n    = WAIT_MGR;
                    pkt_size_n = 12'(res_cnt_n) * 12'(RESULT_BYTES);
                    if (!done)
                        err_n = 1'b1;
                end
            end
            WAIT_MGR: begin
                if (res_cnt == 8'd0) begin
                    state_n    = IDLE;
                    byte_cnt_n = '0;
                    word_cnt_n = '0;
                    to_cnt_n   = '0;
                end else if (i_tmanager_ready) begin
                    out_start_n = 1'b1;
                    state_n     = SEND;
                end
            end
            SEND: begin
                if (i_out_last) begin
                    state_n     = IDLE;
                    des_clear_n = 1'b1;
                    byte_cnt_n  = '0;
                    word_cnt_n  = '0;
                    res_cnt_n   = '0;
                    to_cnt_n    = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        if (res_err)
            err_n = 1'b1;
        tready_n = (state_n == IDLE) || (state_n == RECV);
    end

    assign o_busy  = (state != IDLE);
    assign o_state = state;
endmodule
